riscv_insn_encode: RTL
======================

Name: riscv_insn_encode

Overview:
- Streaming RISC-V RV32I instruction encoder, the inverse of the field decoder.
- Accepts instruction fields, a format select and an immediate over valid/ready, and emits packed 32-bit instruction words over valid/ready.
- Each emitted word carries a sequential word address.
- Used by the boot/program loader and by testbenches to build instruction memory images in hardware.

Parameters:
- ADDR_W, 32, width of out_addr; address counter wraps modulo 2^ADDR_W.
- BASE_ADDR, 0, address of the first emitted word after reset (low 2 bits must be 0).
- CNT_W, 16, width of insn_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  in  7  opcode field
- in_rd  in  5  rd field
- in_funct3  in  3  funct3 field
- in_rs1  in  5  rs1 field
- in_rs2  in  5  rs2 field
- in_funct7  in  7  funct7 field (R only)
- in_imm  in  32  immediate, byte-offset semantics, sign-extended value
- out_valid  out  1  out_insn/out_addr valid
- out_ready  in  1  consumer accepts word
- out_insn  out  32  encoded instruction
- out_addr  out  ADDR_W  address of out_insn
- insn_count  out  CNT_W  words emitted since reset; saturates at all-ones
- err_illegal  out  1  one-cycle pulse: illegal in_fmt accepted
- err_imm  out  1  one-cycle pulse: immediate rejected (see Optional Feature)

Behaviour:
- Handshake:
  - Input transfer occurs when in_valid & in_ready on a rising edge.
  - Output transfer occurs when out_valid & out_ready.
  - out_insn/out_addr are held stable while out_valid & !out_ready.
- Encoding, combinational on accepted fields, then registered:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
  - Fields unused by a format are ignored.
- Buffering: output register plus one skid entry. States:
  - EMPTY: accept → ONE.
  - ONE: accept & !out-transfer → TWO; out-transfer & !accept → EMPTY; both → ONE (output register reloaded).
  - TWO: in_ready=0; out-transfer → ONE, skid entry moves to output register.
  - in_ready = (state != TWO). Registered, so there is no combinational path from out_ready.
- Latency and throughput:
  - A word accepted at edge N is visible on out_* after edge N (out_valid high in cycle N+1) if the buffer was EMPTY.
  - Sustained throughput is 1 word/cycle with out_ready high.
- Address assignment:
  - Address is assigned at acceptance from a next-address counter, which advances by 4 per accepted legal word.
  - Counter wraps modulo 2^ADDR_W.
  - Order is strictly preserved.
- insn_count increments on each output transfer; it saturates and does not wrap.
- Illegal in_fmt (6,7):
  - The bundle is accepted (consumed); no word is enqueued.
  - Address counter is unchanged.
  - err_illegal pulses high the cycle after acceptance.
- Reset:
  - Sets state EMPTY, out_valid=0, in_ready=1 on the cycle after rst, out_insn=0, out_addr=BASE_ADDR.
  - Sets next-address counter=BASE_ADDR, insn_count=0, err_*=0.
  - Reset mid-stream discards both buffered words; no partial output.
  - While rst is high, in_ready=0.

Optional Feature:
- Macro: RISCV_INSN_ENCODE_IMM_CHECK_EN.
- Defined: the immediate is range/alignment checked per format; a violating bundle is consumed and dropped like an illegal format, and err_imm pulses. Checks:
  - I/S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - U: imm[11:0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - R: no check.
- Undefined: no check; the immediate is silently truncated per the bit slices above, and err_imm is tied 0.

Test Plan:
- I fmt, op=0x13 rd=1 f3=0 rs1=0 imm=5 → out_insn=0x00500093, out_addr=BASE_ADDR, insn_count=1.
- Back-to-back, out_ready=1:
  - R op=0x33 rd=3 rs1=1 rs2=2 f7=0 → 0x002081B3.
  - S op=0x23 f3=2 rs1=1 rs2=2 imm=8 → 0x0020A423.
  - B op=0x63 imm=-4 → 0xFE000EE3.
  - U op=0x37 rd=5 imm=0x12345000 → 0x123452B7.
  - J op=0x6F rd=1 imm=2048 → 0x001000EF.
  - Expect one word per cycle, addresses +4 each.
- Backpressure: out_ready=0, offer 3 bundles → 2 accepted, in_ready=0; raise out_ready → 3 words in order, addresses BASE, +4, +8, no duplicates/drops.
- Wrap: ADDR_W=4, BASE_ADDR=0xC, 2 words → out_addr 0xC then 0x0. in_fmt=7 between them → err_illegal pulse, address sequence unchanged.
- Imm check (macro defined): I imm=2048 → err_imm pulse, no output. B imm=3 → err_imm. With macro undefined, I imm=2048 emits imm field 0x800, err_imm=0.
- Reset in state TWO → next cycle out_valid=0, out_addr=BASE_ADDR, insn_count=0; subsequent word gets BASE_ADDR.

Source files
------------

// File: rtl/riscv_insn_encode.sv
// rtl/riscv_insn_encode.sv - streaming RV32I instruction encoder with address tagging and skid buffer
// Optional immediate range/alignment checking: define RISCV_INSN_ENCODE_IMM_CHECK_EN
module riscv_insn_encode #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_insn,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  insn_count,
    output logic              err_illegal,
    output logic              err_imm
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [31:0]         out_insn_q, out_insn_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [31:0]         skid_insn_q, skid_insn_d;
    logic [ADDR_W-1:0]   skid_addr_q, skid_addr_d;
    logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_illegal_q, err_illegal_d;
    logic                err_imm_q, err_imm_d;

    logic [31:0]         enc_insn;
    logic                fmt_legal;
    logic                imm_bad;
    logic                accept;
    logic                enq;
    logic                out_xfer;

    // in_ready is forced low while reset is held; otherwise it is the registered "not full" flag
    assign in_ready    = in_ready_q & ~rst;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_insn    = out_insn_q;
    assign out_addr    = out_addr_q;
    assign insn_count  = cnt_q;
    assign err_illegal = err_illegal_q;
    assign err_imm     = err_imm_q;

    assign accept    = in_valid & in_ready;
    assign fmt_legal = (in_fmt <= FMT_J);
    assign enq       = accept & fmt_legal & ~imm_bad;
    assign out_xfer  = out_valid & out_ready;

    // Pack the accepted fields into the instruction word for the selected format
    always_comb begin
        enc_insn = 32'd0;
        case (in_fmt)
            FMT_R: enc_insn = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: enc_insn = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc_insn = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: enc_insn = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                               in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: enc_insn = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: enc_insn = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                               in_rd, in_opcode};
            default: enc_insn = 32'd0;
        endcase
    end

`ifdef RISCV_INSN_ENCODE_IMM_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s = $signed(in_imm);

    // Flag immediates that cannot be represented exactly by the selected format
    always_comb begin
        imm_bad = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: imm_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            FMT_B:        imm_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
            FMT_U:        imm_bad = |in_imm[11:0];
            FMT_J:        imm_bad = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
            default:      imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

    // Buffer occupancy, output/skid register loading, address counter and status
    always_comb begin
        state_d       = state_q;
        out_insn_d    = out_insn_q;
        out_addr_d    = out_addr_q;
        skid_insn_d   = skid_insn_q;
        skid_addr_d   = skid_addr_q;
        next_addr_d   = next_addr_q;
        cnt_d         = cnt_q;
        err_illegal_d = accept & ~fmt_legal;
        err_imm_d     = accept & fmt_legal & imm_bad;

        case (state_q)
            ST_EMPTY: begin
                if (enq) begin
                    state_d    = ST_ONE;
                    out_insn_d = enc_insn;
                    out_addr_d = next_addr_q;
                end
            end
            ST_ONE: begin
                if (enq && !out_xfer) begin
                    state_d     = ST_TWO;
                    skid_insn_d = enc_insn;
                    skid_addr_d = next_addr_q;
                end else if (enq && out_xfer) begin
                    out_insn_d = enc_insn;
                    out_addr_d = next_addr_q;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    state_d    = ST_ONE;
                    out_insn_d = skid_insn_q;
                    out_addr_d = skid_addr_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (enq) begin
            next_addr_d = next_addr_q + ADDR_W'(4);
        end
        if (out_xfer && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        in_ready_d = (state_d != ST_TWO);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            in_ready_q    <= 1'b1;
            out_insn_q    <= 32'd0;
            out_addr_q    <= BASE_ADDR;
            skid_insn_q   <= 32'd0;
            skid_addr_q   <= BASE_ADDR;
            next_addr_q   <= BASE_ADDR;
            cnt_q         <= '0;
            err_illegal_q <= 1'b0;
            err_imm_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_insn_q    <= out_insn_d;
            out_addr_q    <= out_addr_d;
            skid_insn_q   <= skid_insn_d;
            skid_addr_q   <= skid_addr_d;
            next_addr_q   <= next_addr_d;
            cnt_q         <= cnt_d;
            err_illegal_q <= err_illegal_d;
            err_imm_q     <= err_imm_d;
        end
    end

endmodule
